// File: rtl/jogo_memoria_pkg.sv
// Shared types for the parametrised memory game.
// State codes double as the db_estado debug value.
package jogo_memoria_pkg;

   localparam int ESTADO_W = 4;

   typedef enum logic [ESTADO_W-1:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
`ifdef JOGO_MOSTRA_EN
      MOSTRA       = 4'd2,
`endif
      ESPERA_REP   = 4'd3,
      COMPARA      = 4'd4,
      ESPERA_GRAVA = 4'd5,
      GRAVA        = 4'd6,
      PROX_RODADA  = 4'd7,
      GANHOU       = 4'd8,
      PERDEU       = 4'd9
   } estado_t;

endpackage

// File: rtl/jogo_memoria_if.sv
// Button/LED/debug bundle between the board logic and the game core.
// master = board side, slave = game core.
interface jogo_memoria_if #(
   parameter int NUM_BOTOES = 4,
   parameter int PROF_MAX   = 16
);
   import jogo_memoria_pkg::*;

   logic                    iniciar;
   logic                    nivel;
   logic [NUM_BOTOES-1:0]   botoes;
   logic [NUM_BOTOES-1:0]   leds;
   logic                    ganhou;
   logic                    perdeu;
   logic                    pronto;
   logic                    db_timeout;
   logic [$clog2(PROF_MAX):0] db_rodada;
   logic [ESTADO_W-1:0]     db_estado;

   modport master (
      output iniciar, nivel, botoes,
      input  leds, ganhou, perdeu, pronto,
      input  db_timeout, db_rodada, db_estado
   );

   modport slave (
      input  iniciar, nivel, botoes,
      output leds, ganhou, perdeu, pronto,
      output db_timeout, db_rodada, db_estado
   );

endinterface

// File: rtl/jogo_memoria_ram.sv
// Move storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module jogo_memoria_ram #(
   parameter int NUM_BOTOES = 4,
   parameter int PROF_MAX   = 16,
   localparam int AW        = $clog2(PROF_MAX)
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [NUM_BOTOES-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [NUM_BOTOES-1:0] rdata
);

   logic [NUM_BOTOES-1:0] mem [PROF_MAX];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-game core: FSM, press detector, timeout and round counters.
// Define JOGO_MOSTRA_EN to enable LED playback of the stored sequence.
module jogo_memoria_param
   import jogo_memoria_pkg::*;
#(
   parameter int NUM_BOTOES     = 4,
   parameter int PROF_MAX       = 16,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int MOSTRA_CICLOS  = 500
) (
   input  logic clock,
   input  logic reset,
   jogo_memoria_if.slave io
);

   localparam int AW = $clog2(PROF_MAX);
   localparam int RW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   localparam int NB = NUM_BOTOES;

   if (NUM_BOTOES < 2 || PROF_MAX < 2 || MOSTRA_CICLOS < 1 ||
       (PROF_MAX & (PROF_MAX - 1)) != 0) begin : g_param_err
      $error("jogo_memoria_param: invalid parameters");
   end

   estado_t       estado, prox;
   logic [NB-1:0] botoes_q, jogada, rdata;
   logic [RW-1:0] rodada, tam;
   logic [AW-1:0] addr;
   logic [TW-1:0] tcnt;
   logic          timeout_q, ativo;
   logic          press, valido, jogada_ok;
   logic          espera, expirou, ultimo;

   assign press     = (io.botoes != '0) && (botoes_q == '0);
   assign valido    = (io.botoes != '0) &&
                      ((io.botoes & (io.botoes - NB'(1))) == '0);
   assign jogada_ok = (jogada != '0) &&
                      ((jogada & (jogada - NB'(1))) == '0);
   assign espera    = (estado == ESPERA_REP) || (estado == ESPERA_GRAVA);
   assign expirou   = tcnt == TW'(TIMEOUT_CICLOS);
   assign ultimo    = {1'b0, addr} == (rodada - RW'(1));

`ifdef JOGO_MOSTRA_EN
   localparam int MW = $clog2(2 * MOSTRA_CICLOS);
   logic [MW-1:0] mcnt;
   logic          fim_entrada, aceso;

   assign fim_entrada = mcnt == MW'(2 * MOSTRA_CICLOS - 1);
   assign aceso       = mcnt < MW'(MOSTRA_CICLOS);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         mcnt <= '0;
      else if (estado == MOSTRA && !fim_entrada)
         mcnt <= mcnt + 1'b1;
      else
         mcnt <= '0;
   end
`endif

   jogo_memoria_ram #(
      .NUM_BOTOES(NB),
      .PROF_MAX  (PROF_MAX)
   ) u_ram (
      .clock(clock),
      .we   (estado == GRAVA),
      .waddr(rodada[AW-1:0]),
      .wdata(jogada),
      .raddr(addr),
      .rdata(rdata)
   );

   always_comb begin
      prox = estado;
      unique case (estado)
         INICIAL:      if (io.iniciar) prox = PREPARA;
         PREPARA:      prox = ESPERA_GRAVA;
`ifdef JOGO_MOSTRA_EN
         MOSTRA:       if (fim_entrada && ultimo) prox = ESPERA_REP;
`endif
         ESPERA_REP: begin
            if (press)        prox = COMPARA;
            else if (expirou) prox = PERDEU;
         end
         COMPARA: begin
            if (!jogada_ok || jogada != rdata) prox = PERDEU;
            else if (ultimo)
               prox = (rodada == tam) ? GANHOU : ESPERA_GRAVA;
            else                               prox = ESPERA_REP;
         end
         ESPERA_GRAVA: begin
            if (press && valido) prox = GRAVA;
            else if (expirou)    prox = PERDEU;
         end
         GRAVA:        prox = PROX_RODADA;
`ifdef JOGO_MOSTRA_EN
         PROX_RODADA:  prox = MOSTRA;
`else
         PROX_RODADA:  prox = ESPERA_REP;
`endif
         GANHOU, PERDEU: if (io.iniciar) prox = PREPARA;
         default:      prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= INICIAL;
         botoes_q  <= '0;
         jogada    <= '0;
         rodada    <= '0;
         tam       <= '0;
         addr      <= '0;
         tcnt      <= '0;
         timeout_q <= 1'b0;
         ativo     <= 1'b0;
      end else begin
         estado   <= prox;
         botoes_q <= io.botoes;
         ativo    <= 1'b1;
         // the counter only survives while staying in a wait state
         tcnt     <= (espera && prox == estado) ? tcnt + 1'b1 : '0;
         if (espera && prox == PERDEU) timeout_q <= 1'b1;
         unique case (estado)
            PREPARA: begin
               rodada    <= '0;
               addr      <= '0;
               timeout_q <= 1'b0;
               tam       <= io.nivel ? RW'(PROF_MAX) : RW'(PROF_MAX / 2);
            end
`ifdef JOGO_MOSTRA_EN
            MOSTRA: begin
               if (fim_entrada) addr <= ultimo ? '0 : addr + 1'b1;
            end
`endif
            ESPERA_REP: begin
               if (press) jogada <= io.botoes;
            end
            ESPERA_GRAVA: begin
               if (press && valido) jogada <= io.botoes;
            end
            COMPARA: begin
               if (prox == ESPERA_REP) addr <= addr + 1'b1;
            end
            PROX_RODADA: begin
               rodada <= rodada + 1'b1;
               addr   <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      io.leds = ativo ? io.botoes : '0;
`ifdef JOGO_MOSTRA_EN
      if (estado == MOSTRA) io.leds = aceso ? rdata : '0;
`endif
   end

   assign io.ganhou     = estado == GANHOU;
   assign io.perdeu     = estado == PERDEU;
   assign io.pronto     = (estado == GANHOU) || (estado == PERDEU);
   assign io.db_timeout = timeout_q;
   assign io.db_rodada  = rodada;
   assign io.db_estado  = estado;

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised memory-game core, successor to the fixed 4-button, 16-move `jogo_desafio_memoria`. The player builds the sequence: in each round, every stored move is repeated, then one new move is entered and written to internal RAM. The core adds:
- configurable button count and sequence depth;
- a level input that selects the winning length;
- a press-timeout;
- optional LED playback of the stored sequence.

It sits between debounced button inputs and the board LED/7-segment debug logic.

## Interface
- `NUM_BOTOES`, 4: buttons/LEDs; ≥2.
- `PROF_MAX`, 16: RAM depth = max sequence length; power of 2, ≥2.
- `TIMEOUT_CICLOS`, 5000: idle cycles allowed while waiting for a press.
- `MOSTRA_CICLOS`, 500: playback on/off time per entry (used only with `JOGO_MOSTRA_EN`).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `iniciar` in 1: start/restart; honoured only in INICIAL, GANHOU, PERDEU.
- `nivel` in 1: sampled on start; 0 → TAM = `PROF_MAX/2`, 1 → TAM = `PROF_MAX`.
- `botoes` in `NUM_BOTOES`: synchronised button levels.
- `leds` out `NUM_BOTOES`: player feedback.
- `ganhou` out 1: game won.
- `perdeu` out 1: game lost.
- `pronto` out 1: game finished.
- `db_timeout` out 1: loss was caused by timeout.
- `db_rodada` out `$clog2(PROF_MAX)+1`: current round R.
- `db_estado` out 4: state code.

## Operation
**Press detection**
- A press is `botoes != 0` in a cycle whose previous-cycle `botoes` (registered) was 0.
- The value is captured in `jogada`.
- A press is valid only if exactly one bit is set.

**States** (`db_estado` code in brackets)
- INICIAL [0]: on `iniciar`, go to PREPARA.
- PREPARA [1]:
  - R=0, addr=0, timeout counter cleared, `nivel` latched.
  - Next: MOSTRA when enabled and R>0, else ESPERA_REP when R>0, else ESPERA_GRAVA.
- MOSTRA [2]:
  - Plays entries 0..R-1.
  - `botoes` is ignored and the timer is frozen.
  - Then ESPERA_REP with addr=0.
- ESPERA_REP [3]: on press, capture and go to COMPARA.
- COMPARA [4]:
  - If `jogada` is invalid or ≠ RAM[addr], go to PERDEU.
  - Else if addr = R-1: go to GANHOU if R = TAM, else ESPERA_GRAVA.
  - Else addr++ and return to ESPERA_REP.
- ESPERA_GRAVA [5]:
  - A valid press goes to GRAVA.
  - An invalid (multi-bit) press is ignored and the timer is not reset.
- GRAVA [6]: RAM[R] ← `jogada`, then PROX_RODADA.
- PROX_RODADA [7]: R++, addr=0, then MOSTRA or ESPERA_REP.
- GANHOU [8]: `ganhou=1`, `pronto=1`. Held until `iniciar`, which goes to PREPARA.
- PERDEU [9]: `perdeu=1`, `pronto=1`. Held until `iniciar`, which goes to PREPARA.

**Timeout**
- A counter runs in ESPERA_REP and ESPERA_GRAVA.
- It clears on every accepted press and on state entry.
- Reaching `TIMEOUT_CICLOS` goes to PERDEU with `db_timeout=1`.
- A press on the same cycle as the timeout wins: the press is taken.

**Other rules**
- `leds = botoes` in all states except MOSTRA.
- RAM contents are not cleared by reset; only entries written in the current game are read.

## Timing
- Reset (async assert): state INICIAL; all outputs 0, including `leds`, `db_rodada` and `db_estado`. Release is synchronous to `clock`.
- Outputs are Moore, decoded from registered state.
- Press seen at edge k → COMPARA after k → `ganhou`/`perdeu`/`pronto` valid after edge k+1.
- Write path: press at edge k → GRAVA after k, RAM written at edge k+1 → `db_rodada` increments after edge k+2.
- Timeout: `perdeu` is asserted exactly `TIMEOUT_CICLOS`+1 edges after entering a wait state with no press.
- `iniciar` held over several cycles in a final state restarts once. Any `iniciar` still high on reaching PREPARA is ignored.

## Configuration
- `JOGO_MOSTRA_EN` defined:
  - MOSTRA state exists.
  - Each entry is shown on `leds` for `MOSTRA_CICLOS`, then `leds=0` for `MOSTRA_CICLOS`.
  - Total playback time is 2·R·`MOSTRA_CICLOS` cycles.
- `JOGO_MOSTRA_EN` undefined:
  - No MOSTRA state and no playback counter.
  - Transitions go straight to ESPERA_REP.
  - Code 2 is unused.

## Structure
- Package `jogo_memoria_pkg`: state enum with the codes above, and the `db_estado` width.
- Sub-module `jogo_memoria_ram`: `NUM_BOTOES` × `PROF_MAX`, synchronous write, asynchronous read.
- FSM, counters and press detector live in the top module.

## Test plan
- Reset: assert `reset`=0 mid-game at R=3 → all outputs 0 and `db_estado`=0 immediately; after `iniciar`, R=0.
- Win, `nivel`=0, `PROF_MAX`=16 (TAM=8): enter and repeat the pattern 0001, 0010, 0100, 1000, … with correct repetitions → `ganhou`=1, `pronto`=1, `db_rodada`=8, `perdeu`=0.
- Wrong move: round R=3, second repeat press is 0100 where 0010 is stored → `perdeu`=1 two edges after the press, `db_timeout`=0.
- Timeout, with `TIMEOUT_CICLOS`=20: no press after start → `perdeu`=1, `db_timeout`=1 after 21 edges.
- Invalid press: 0011 in ESPERA_GRAVA → ignored, R unchanged. The same 0011 in ESPERA_REP → `perdeu`=1.
- Playback (`JOGO_MOSTRA_EN`, `MOSTRA_CICLOS`=4) at R=2 → `leds`=e0 for 4 cycles, 0 for 4, e1 for 4, 0 for 4; presses during playback are ignored.
